// File: rtl/uart_frame_check_if.sv
// UART frame-check bus: sampler strobes and config in,
// per-frame results and error statistics out.
interface uart_frame_check_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              bit_valid;
  logic              bit_in;
  logic [2:0]        par_mode;
  logic              stop2;
  logic              clr_stat;
  logic              busy;
  logic              frame_done;
  logic [DATA_W-1:0] pdata;
  logic              par_err;
  logic              stop_err;
  logic              par_sticky;
  logic              stop_sticky;
  logic [CNT_W-1:0]  par_err_cnt;
  logic [CNT_W-1:0]  stop_err_cnt;

  modport master (
    output start, bit_valid, bit_in,
    output par_mode, stop2, clr_stat,
    input  busy, frame_done, pdata,
    input  par_err, stop_err,
    input  par_sticky, stop_sticky,
    input  par_err_cnt, stop_err_cnt
  );

  modport slave (
    input  start, bit_valid, bit_in,
    input  par_mode, stop2, clr_stat,
    output busy, frame_done, pdata,
    output par_err, stop_err,
    output par_sticky, stop_sticky,
    output par_err_cnt, stop_err_cnt
  );
endinterface

// File: rtl/uart_frame_check.sv
// UART RX frame checker: LSB-first shift-in, parity and
// stop-bit checks, sticky flags and saturating counters.
module uart_frame_check #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic             clk,
  input logic             rst,
  uart_frame_check_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  localparam logic [3:0] LAST = 4'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t state, state_n;

  logic [2:0]        mode_q;
  logic              stop2_q;
  logic [3:0]        bcnt;
  logic [DATA_W-1:0] shreg;
  logic              stop_acc;
  logic              stop_seen;
  logic              par_pend;

  logic              done_q;
  logic [DATA_W-1:0] pdata_q;
  logic              perr_q;
  logic              serr_q;
  logic              psticky_q;
  logic              ssticky_q;
  logic [CNT_W-1:0]  pcnt_q;
  logic [CNT_W-1:0]  scnt_q;

  logic has_par;
  logic exp_par;
  logic fin;
  logic serr_n;

  assign has_par = (mode_q >= 3'd1)
                && (mode_q <= 3'd4);

  always_comb begin
    exp_par = 1'b0;
    unique case (1'b1)
      (mode_q == 3'd1): exp_par = ^shreg;
      (mode_q == 3'd2): exp_par = ~^shreg;
      (mode_q == 3'd3): exp_par = 1'b1;
      default:          exp_par = 1'b0;
    endcase
  end

  // last stop bit: second one when two are configured
  assign fin = (state == STOP) && bus.bit_valid
            && (!stop2_q || stop_seen);
  assign serr_n = stop_acc | ~bus.bit_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.start) state_n = DATA;
      DATA:
        if (bus.bit_valid && bcnt == LAST)
          state_n = has_par ? PARITY : STOP;
      PARITY:
        if (bus.bit_valid) state_n = STOP;
      STOP:
        if (fin) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= '0;
      stop2_q   <= 1'b0;
      bcnt      <= '0;
      shreg     <= '0;
      stop_acc  <= 1'b0;
      stop_seen <= 1'b0;
      par_pend  <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        mode_q    <= bus.par_mode;
        stop2_q   <= bus.stop2;
        bcnt      <= '0;
        shreg     <= '0;
        stop_acc  <= 1'b0;
        stop_seen <= 1'b0;
        par_pend  <= 1'b0;
      end
      if (state == DATA && bus.bit_valid) begin
        shreg <= {bus.bit_in, shreg[DATA_W-1:1]};
        bcnt  <= bcnt + 4'd1;
      end
      if (state == PARITY && bus.bit_valid)
        par_pend <= bus.bit_in != exp_par;
      if (state == STOP && bus.bit_valid) begin
        stop_acc  <= serr_n;
        stop_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q    <= 1'b0;
      pdata_q   <= '0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      psticky_q <= 1'b0;
      ssticky_q <= 1'b0;
      pcnt_q    <= '0;
      scnt_q    <= '0;
    end else begin
      done_q <= fin;
      if (fin) begin
        pdata_q <= shreg;
        perr_q  <= par_pend;
        serr_q  <= serr_n;
      end
      // an error on the clearing edge wins over the clear
      if (fin && par_pend) begin
        psticky_q <= 1'b1;
        if (bus.clr_stat)      pcnt_q <= CNT_W'(1);
        else if (pcnt_q != CMAX) pcnt_q <= pcnt_q + CNT_W'(1);
      end else if (bus.clr_stat) begin
        psticky_q <= 1'b0;
        pcnt_q    <= '0;
      end
      if (fin && serr_n) begin
        ssticky_q <= 1'b1;
        if (bus.clr_stat)      scnt_q <= CNT_W'(1);
        else if (scnt_q != CMAX) scnt_q <= scnt_q + CNT_W'(1);
      end else if (bus.clr_stat) begin
        ssticky_q <= 1'b0;
        scnt_q    <= '0;
      end
    end
  end

  assign bus.busy         = state != IDLE;
  assign bus.frame_done   = done_q;
  assign bus.pdata        = pdata_q;
  assign bus.par_err      = perr_q;
  assign bus.stop_err     = serr_q;
  assign bus.par_sticky   = psticky_q;
  assign bus.stop_sticky  = ssticky_q;
  assign bus.par_err_cnt  = pcnt_q;
  assign bus.stop_err_cnt = scnt_q;
endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench for uart_frame_check: three instances
// (8/8, 5/8, 8/2) checked through a result scoreboard.
module tb_uart_frame_check;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, bit_valid, bit_in, stop2, clr_stat;
  logic [2:0] par_mode;
  int         sel;

  uart_frame_check_if #(.DATA_W(8), .CNT_W(8)) b8();
  uart_frame_check_if #(.DATA_W(5), .CNT_W(8)) b5();
  uart_frame_check_if #(.DATA_W(8), .CNT_W(2)) b2();

  assign b8.start     = start && sel == 0;
  assign b8.bit_valid = bit_valid && sel == 0;
  assign b8.bit_in    = bit_in;
  assign b8.par_mode  = par_mode;
  assign b8.stop2     = stop2;
  assign b8.clr_stat  = clr_stat && sel == 0;
  assign b5.start     = start && sel == 1;
  assign b5.bit_valid = bit_valid && sel == 1;
  assign b5.bit_in    = bit_in;
  assign b5.par_mode  = par_mode;
  assign b5.stop2     = stop2;
  assign b5.clr_stat  = clr_stat && sel == 1;
  assign b2.start     = start && sel == 2;
  assign b2.bit_valid = bit_valid && sel == 2;
  assign b2.bit_in    = bit_in;
  assign b2.par_mode  = par_mode;
  assign b2.stop2     = stop2;
  assign b2.clr_stat  = clr_stat && sel == 2;

  uart_frame_check #(.DATA_W(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .bus(b8.slave));
  uart_frame_check #(.DATA_W(5), .CNT_W(8)) u5 (
    .clk(clk), .rst(rst), .bus(b5.slave));
  uart_frame_check #(.DATA_W(8), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave));

  logic       busy_o, fd_o, pe_o, se_o, ps_o, ss_o;
  logic [8:0] pd_o;
  logic [7:0] pc_o, sc_o;

  always_comb begin
    busy_o = b8.busy;
    fd_o   = b8.frame_done;
    pd_o   = 9'(b8.pdata);
    pe_o   = b8.par_err;
    se_o   = b8.stop_err;
    ps_o   = b8.par_sticky;
    ss_o   = b8.stop_sticky;
    pc_o   = b8.par_err_cnt;
    sc_o   = b8.stop_err_cnt;
    if (sel == 1) begin
      busy_o = b5.busy;
      fd_o   = b5.frame_done;
      pd_o   = 9'(b5.pdata);
      pe_o   = b5.par_err;
      se_o   = b5.stop_err;
      ps_o   = b5.par_sticky;
      ss_o   = b5.stop_sticky;
      pc_o   = b5.par_err_cnt;
      sc_o   = b5.stop_err_cnt;
    end else if (sel == 2) begin
      busy_o = b2.busy;
      fd_o   = b2.frame_done;
      pd_o   = 9'(b2.pdata);
      pe_o   = b2.par_err;
      se_o   = b2.stop_err;
      ps_o   = b2.par_sticky;
      ss_o   = b2.stop_sticky;
      pc_o   = 8'(b2.par_err_cnt);
      sc_o   = 8'(b2.stop_err_cnt);
    end
  end

  typedef struct {
    logic [8:0] pd;
    logic       pe;
    logic       se;
    logic       ps;
    logic       ss;
    logic [7:0] pc;
    logic [7:0] sc;
  } exp_t;

  exp_t sb[$];

  logic [7:0] mpc[3];
  logic [7:0] msc[3];
  logic       mps[3];
  logic       mss[3];
  logic [7:0] cmax[3];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] o,
                     logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mpc[k] = '0;
      msc[k] = '0;
      mps[k] = 1'b0;
      mss[k] = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b, int gap);
    repeat (gap) cyc();
    bit_in    = b;
    bit_valid = 1'b1;
    cyc();
    bit_valid = 1'b0;
  endtask

  task automatic pulse_start(logic [2:0] m, logic s2);
    par_mode = m;
    stop2    = s2;
    start    = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    cyc();
    start     = 1'b0;
    bit_valid = 1'b0;
    par_mode  = ~m;
    stop2     = ~s2;
  endtask

  task automatic frame(int w, logic [8:0] d,
                       logic [2:0] m, logic pb,
                       logic s2, logic st1, logic st2,
                       logic clr, logic mid);
    exp_t e;
    logic hp, ep, perr, serr;
    int   k, t;
    k    = sel;
    hp   = (m >= 3'd1) && (m <= 3'd4);
    case (m)
      3'd1:    ep = ^d;
      3'd2:    ep = ~^d;
      3'd3:    ep = 1'b1;
      default: ep = 1'b0;
    endcase
    perr = hp && (pb != ep);
    serr = !st1 || (s2 && !st2);
    if (perr) begin
      mps[k] = 1'b1;
      if (clr)                  mpc[k] = 8'd1;
      else if (mpc[k] != cmax[k]) mpc[k] = mpc[k] + 8'd1;
    end else if (clr) begin
      mps[k] = 1'b0;
      mpc[k] = '0;
    end
    if (serr) begin
      mss[k] = 1'b1;
      if (clr)                  msc[k] = 8'd1;
      else if (msc[k] != cmax[k]) msc[k] = msc[k] + 8'd1;
    end else if (clr) begin
      mss[k] = 1'b0;
      msc[k] = '0;
    end
    e = '{d, perr, serr, mps[k], mss[k], mpc[k], msc[k]};
    sb.push_back(e);

    pulse_start(m, s2);
    chk("busy_rise", 32'(busy_o), 32'd1);
    chk("done_low", 32'(fd_o), 32'd0);
    for (int i = 0; i < w; i++) begin
      send_bit(d[i], (i % 3 == 1) ? 2 : 0);
      if (mid && i == 1) begin
        start = 1'b1;
        cyc();
        start = 1'b0;
      end
    end
    if (hp) send_bit(pb, 1);
    if (s2) begin
      send_bit(st1, 0);
      chk("stop_wait", 32'(busy_o), 32'd1);
    end
    clr_stat = clr;
    send_bit(s2 ? st2 : st1, 0);
    clr_stat = 1'b0;

    t = 0;
    while (fd_o !== 1'b1 && t < 8) begin
      cyc();
      t++;
    end
    chk("done_latency", t, 0);
    e = sb.pop_front();
    chk("pdata", 32'(pd_o), 32'(e.pd));
    chk("par_err", 32'(pe_o), 32'(e.pe));
    chk("stop_err", 32'(se_o), 32'(e.se));
    chk("par_sticky", 32'(ps_o), 32'(e.ps));
    chk("stop_sticky", 32'(ss_o), 32'(e.ss));
    chk("par_cnt", 32'(pc_o), 32'(e.pc));
    chk("stop_cnt", 32'(sc_o), 32'(e.sc));
    chk("busy_fall", 32'(busy_o), 32'd0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(fd_o), 32'd0);
    chk({tag, "_pdata"}, 32'(pd_o), 32'd0);
    chk({tag, "_perr"}, 32'(pe_o), 32'd0);
    chk({tag, "_serr"}, 32'(se_o), 32'd0);
    chk({tag, "_psticky"}, 32'(ps_o), 32'd0);
    chk({tag, "_ssticky"}, 32'(ss_o), 32'd0);
    chk({tag, "_pcnt"}, 32'(pc_o), 32'd0);
    chk({tag, "_scnt"}, 32'(sc_o), 32'd0);
  endtask

  initial begin
    int seen;
    cmax[0] = 8'd255;
    cmax[1] = 8'd255;
    cmax[2] = 8'd3;
    model_reset();
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    par_mode  = 3'd0;
    stop2     = 1'b0;
    clr_stat  = 1'b0;
    sel       = 0;
    rst       = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // stray bit_valid in idle is ignored
    send_bit(1'b1, 0);
    chk("idle_bv", 32'(busy_o), 32'd0);

    frame(8, 9'h0A5, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frame(8, 9'h03C, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frame(8, 9'h03C, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frame(8, 9'h00F, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(8, 9'h0C3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    sel = 1;
    cyc();
    frame(5, 9'h00D, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    frame(5, 9'h012, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frame(5, 9'h01F, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    sel = 2;
    cyc();
    for (int n = 0; n < 5; n++)
      frame(8, 9'h001, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1,
            1'b0, 1'b0);
    frame(8, 9'h001, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1,
          1'b1, 1'b0);
    clr_stat = 1'b1;
    cyc();
    clr_stat = 1'b0;
    chk("clr_psticky", 32'(ps_o), 32'd0);
    chk("clr_pcnt", 32'(pc_o), 32'd0);

    sel = 0;
    cyc();
    pulse_start(3'd1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (4) begin
      cyc();
      if (fd_o !== 1'b0) seen++;
    end
    chk("midrst_nodone", seen, 0);
    frame(8, 9'h0FF, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
